// File: rtl/parking_keypad_entry.sv
// parking_keypad_entry: debounced gate sensors plus two-digit keypad capture FSM.
// Optional entry timeout enabled by defining PARKING_KEYPAD_TIMEOUT_EN.
module parking_keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       raw_entry_sensor,
  input  logic       raw_exit_sensor,
  input  logic       key_strobe,
  input  logic [1:0] key_code,
  input  logic       key_clear,
  output logic       entry_sensor,
  output logic       exit_sensor,
  output logic [1:0] password_1,
  output logic [1:0] password_2,
  output logic       pwd_valid,
  output logic       timeout_pulse
);
  typedef enum logic [1:0] {IDLE, DIGIT1, DIGIT2, VALID} state_t;
  state_t state, state_d;
  logic [1:0] raw, filt, p1_d, p2_d;
  assign raw = {raw_exit_sensor, raw_entry_sensor};
  // Counter runs only while raw disagrees with the filtered level
  for (genvar g = 0; g < 2; g++) begin : deb
    logic f;
    logic [7:0] c;
    always_ff @(posedge clock) begin
      if (reset) begin
        f <= 1'b0;
        c <= '0;
      end else if (raw[g] == f) begin
        c <= '0;
      end else if (c == 8'(DEBOUNCE_CYCLES - 1)) begin
        f <= ~f;
        c <= '0;
      end else begin
        c <= c + 8'd1;
      end
    end
    assign filt[g] = f;
  end
  assign entry_sensor = filt[0];
  assign exit_sensor  = filt[1];
  assign pwd_valid    = state == VALID;
`ifdef PARKING_KEYPAD_TIMEOUT_EN
  logic [15:0] tcnt, tcnt_d;
  logic tmo, pulse_d;
  assign tmo = (state == DIGIT1 || state == DIGIT2) && tcnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt          <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      tcnt          <= tcnt_d;
      timeout_pulse <= pulse_d;
    end
  end
`else
  assign timeout_pulse = 1'b0;
`endif
  always_comb begin
    state_d = state;
    p1_d    = password_1;
    p2_d    = password_2;
`ifdef PARKING_KEYPAD_TIMEOUT_EN
    tcnt_d  = '0;
    pulse_d = 1'b0;
`endif
    if (state == IDLE) begin
      state_d = entry_sensor ? DIGIT1 : IDLE;
    end else if (!entry_sensor) begin
      state_d = IDLE;
      p1_d    = '0;
      p2_d    = '0;
    end else if (key_clear) begin
      state_d = DIGIT1;
      p1_d    = '0;
      p2_d    = '0;
    end else if (key_strobe && state == DIGIT1) begin
      state_d = DIGIT2;
      p1_d    = key_code;
    end else if (key_strobe && state == DIGIT2) begin
      state_d = VALID;
      p2_d    = key_code;
`ifdef PARKING_KEYPAD_TIMEOUT_EN
    end else if (tmo) begin
      state_d = DIGIT1;
      p1_d    = '0;
      p2_d    = '0;
      pulse_d = 1'b1;
    end else if (state != VALID) begin
      tcnt_d  = tcnt + 16'd1;
`endif
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      password_1 <= '0;
      password_2 <= '0;
    end else begin
      state      <= state_d;
      password_1 <= p1_d;
      password_2 <= p2_d;
    end
  end
endmodule

// File: tb/tb_parking_keypad_entry.sv
// tb_parking_keypad_entry: directed stimulus checked against a queue-based model of the keypad entry rules.
module tb_parking_keypad_entry;
  localparam int D = 4;
  localparam int T = 64;
  logic clock = 1'b0;
  logic reset, raw_entry_sensor, raw_exit_sensor, key_strobe, key_clear;
  logic [1:0] key_code;
  logic entry_sensor, exit_sensor, pwd_valid, timeout_pulse;
  logic [1:0] password_1, password_2;
  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  parking_keypad_entry #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset),
    .raw_entry_sensor(raw_entry_sensor), .raw_exit_sensor(raw_exit_sensor),
    .key_strobe(key_strobe), .key_code(key_code), .key_clear(key_clear),
    .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
    .password_1(password_1), .password_2(password_2),
    .pwd_valid(pwd_valid), .timeout_pulse(timeout_pulse)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each sensor flips once its last D samples all disagree with it;
  // the keypad is a list of captured digits that exists only while a car is present.
  logic [D-1:0] hist [2];
  int hcnt [2];
  bit m_filt [2];
  bit armed, m_pulse;
  int digits[$];
  int idle;
  always @(posedge clock) begin
    bit r [2];
    r[0] = raw_entry_sensor;
    r[1] = raw_exit_sensor;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        hist[i] = '0;
        hcnt[i] = 0;
        m_filt[i] = 1'b0;
      end
      armed = 1'b0;
      m_pulse = 1'b0;
      digits.delete();
      idle = 0;
    end else begin
      m_pulse = 1'b0;
      if (!armed) begin
        armed = m_filt[0];
        idle = 0;
      end else if (!m_filt[0]) begin
        armed = 1'b0;
        digits.delete();
      end else if (key_clear) begin
        digits.delete();
        idle = 0;
      end else if (key_strobe && digits.size() < 2) begin
        digits.push_back(int'(key_code));
        idle = 0;
      end else if (digits.size() < 2) begin
`ifdef PARKING_KEYPAD_TIMEOUT_EN
        idle++;
        if (idle == T) begin
          digits.delete();
          idle = 0;
          m_pulse = 1'b1;
        end
`endif
      end
      for (int i = 0; i < 2; i++) begin
        hist[i] = {hist[i][D-2:0], r[i]};
        if (hcnt[i] < D) hcnt[i]++;
        if (hcnt[i] == D && hist[i] == {D{~m_filt[i]}}) begin
          m_filt[i] = ~m_filt[i];
          hcnt[i] = 0;
        end
      end
    end
  end

  always @(posedge clock) begin
    #2;
    if (started) begin
      chk("entry_sensor", int'(entry_sensor), int'(m_filt[0]));
      chk("exit_sensor", int'(exit_sensor), int'(m_filt[1]));
      chk("password_1", int'(password_1), digits.size() >= 1 ? digits[0] : 0);
      chk("password_2", int'(password_2), digits.size() >= 2 ? digits[1] : 0);
      chk("pwd_valid", int'(pwd_valid), int'(digits.size() == 2));
      chk("timeout_pulse", int'(timeout_pulse), int'(m_pulse));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic key(input logic [1:0] c, input logic clr, input logic stb);
    key_code = c;
    key_clear = clr;
    key_strobe = stb;
    @(negedge clock);
    key_strobe = 1'b0;
    key_clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    raw_entry_sensor = 1'b1;
    raw_exit_sensor = 1'b1;
    key_strobe = 1'b1;
    key_clear = 1'b0;
    key_code = 2'd3;
    step(1);
    started = 1'b1;
    step(5);
    chk("reset_all_zero", int'({entry_sensor, exit_sensor, password_1, password_2, pwd_valid, timeout_pulse}), 0);
    key_strobe = 1'b0;
    raw_entry_sensor = 1'b0;
    raw_exit_sensor = 1'b0;
    reset = 1'b0;
    step(2);
    raw_entry_sensor = 1'b1;
    step(3);
    raw_entry_sensor = 1'b0;
    step(2);
    chk("glitch_3_blocked", int'(entry_sensor), 0);
    raw_entry_sensor = 1'b1;
    step(3);
    chk("debounce_edge3", int'(entry_sensor), 0);
    step(1);
    chk("debounce_edge4", int'(entry_sensor), 1);
    step(2);
    key(2'd1, 1'b0, 1'b1);
    chk("first_digit", int'(password_1), 1);
    chk("not_valid_yet", int'(pwd_valid), 0);
    key(2'd2, 1'b0, 1'b1);
    chk("normal_entry", int'({password_1, password_2, pwd_valid}), 5'b01_10_1);
    key(2'd3, 1'b0, 1'b1);
    chk("third_strobe_ignored", int'({password_1, password_2, pwd_valid}), 5'b01_10_1);
    raw_entry_sensor = 1'b0;
    step(4);
    chk("leave_still_valid", int'(pwd_valid), 1);
    step(1);
    chk("car_left", int'({password_1, password_2, pwd_valid}), 0);
    raw_entry_sensor = 1'b1;
    step(6);
    key(2'd3, 1'b0, 1'b1);
    chk("abort_first", int'(password_1), 3);
    key(2'd2, 1'b1, 1'b1);
    chk("abort_cleared", int'({password_1, pwd_valid}), 0);
    key(2'd1, 1'b0, 1'b1);
    chk("after_abort_digit1", int'({password_1, password_2, pwd_valid}), 5'b01_00_0);
`ifdef PARKING_KEYPAD_TIMEOUT_EN
    step(T - 1);
    chk("timeout_not_yet", int'({timeout_pulse, password_1}), 3'b0_01);
    step(1);
    chk("timeout_fires", int'({timeout_pulse, password_1}), 3'b1_00);
    step(1);
    chk("timeout_one_cycle", int'(timeout_pulse), 0);
`else
    step(T + 1);
    chk("no_timeout_retained", int'({timeout_pulse, password_1}), 3'b0_01);
`endif
    key(2'd0, 1'b1, 1'b0);
    key(2'd3, 1'b0, 1'b1);
    chk("pre_reset_digit2", int'(password_1), 3);
    reset = 1'b1;
    step(1);
    chk("reset_mid_entry", int'({entry_sensor, exit_sensor, password_1, password_2, pwd_valid, timeout_pulse}), 0);
    reset = 1'b0;
    key(2'd2, 1'b0, 1'b1);
    chk("idle_after_reset", int'({password_1, pwd_valid}), 0);
    step(5);
    for (int i = 0; i < 4; i++) begin
      key(2'(i), 1'b0, 1'b1);
      key(2'(3 - i), 1'b0, 1'b1);
      chk("pattern_pair", int'({password_1, password_2}), (i << 2) | (3 - i));
      raw_entry_sensor = 1'b0;
      step(2);
      raw_entry_sensor = 1'b1;
      key(2'd0, 1'b1, 1'b0);
    end
    raw_exit_sensor = 1'b1;
    step(2);
    raw_exit_sensor = 1'b0;
    step(1);
    chk("exit_glitch", int'(exit_sensor), 0);
    raw_exit_sensor = 1'b1;
    step(3);
    chk("exit_edge3", int'(exit_sensor), 0);
    step(1);
    chk("exit_edge4", int'(exit_sensor), 1);
    step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/parking_keypad_entry.md
PARKING_KEYPAD_ENTRY -- requirements
Module: parking_keypad_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive cycles a raw sensor must differ from its filtered value before the filter output changes (range 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of idle cycles allowed between key presses during code entry (range 2..65535).
REQ-003 SHALL have port clock  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port raw_entry_sensor  input  1  undebounced gate-entry presence sensor.
REQ-006 SHALL have port raw_exit_sensor  input  1  undebounced gate-exit presence sensor.
REQ-007 SHALL have port key_strobe  input  1  one-cycle pulse; key_code is valid when it is high.
REQ-008 SHALL have port key_code  input  2  keypad digit, 0..3.
REQ-009 SHALL have port key_clear  input  1  driver abort; discards any partial code.
REQ-010 SHALL have port entry_sensor  output  1  debounced raw_entry_sensor, feeding the car_parking controller.
REQ-011 SHALL have port exit_sensor  output  1  debounced raw_exit_sensor, feeding the car_parking controller.
REQ-012 SHALL have port password_1  output  2  first captured digit.
REQ-013 SHALL have port password_2  output  2  second captured digit.
REQ-014 SHALL have port pwd_valid  output  1  level; high while both digits are captured.
REQ-015 SHALL have port timeout_pulse  output  1  one-cycle flag marking an entry timeout.

Function
REQ-016 Each debouncer SHALL keep a counter that clears whenever the raw input equals the filtered output and increments otherwise.
REQ-017 The filtered output SHALL toggle, and its counter clear, on the edge where the counter reaches DEBOUNCE_CYCLES; glitches shorter than DEBOUNCE_CYCLES cycles SHALL never propagate.
REQ-018 The FSM SHALL have exactly four states: IDLE, DIGIT1, DIGIT2, VALID; only the debounced entry_sensor SHALL drive the FSM.
REQ-019 IDLE SHALL move to DIGIT1 when entry_sensor=1; key_strobe SHALL be ignored in IDLE.
REQ-020 DIGIT1 with key_strobe SHALL load password_1<=key_code and move to DIGIT2.
REQ-021 DIGIT2 with key_strobe SHALL load password_2<=key_code and move to VALID.
REQ-022 pwd_valid SHALL equal 1 exactly when the state is VALID (registered, one cycle after the second key_strobe edge); key_strobe SHALL be ignored in VALID.
REQ-023 In DIGIT1, DIGIT2 or VALID, entry_sensor=0 SHALL force IDLE and clear both passwords to 0; this SHALL take priority over key_clear and key_strobe in the same cycle.
REQ-024 In DIGIT1, DIGIT2 or VALID, key_clear=1 with entry_sensor=1 SHALL force DIGIT1 and clear both passwords; key_clear SHALL take priority over a simultaneous key_strobe.
REQ-025 password_1 and password_2 SHALL hold their values in every state except when loaded or cleared as specified above.

Reset
REQ-026 With reset=1 at a clock edge, the block SHALL load: state=IDLE; entry_sensor, exit_sensor, password_1, password_2, pwd_valid, timeout_pulse all 0; all counters 0.
REQ-027 Reset SHALL override every other input, including mid-debounce and mid-entry; no output SHALL change asynchronously.

Configuration
REQ-028 Macro PARKING_KEYPAD_TIMEOUT_EN defined: in DIGIT1/DIGIT2 a counter SHALL clear on each accepted key_strobe and on state entry, and otherwise increment.
REQ-029 With PARKING_KEYPAD_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL move to DIGIT1, clear both passwords and assert timeout_pulse for one cycle; entry_sensor=0 and key_clear SHALL take priority over the timeout.
REQ-030 Macro undefined: no timeout counter SHALL exist, timeout_pulse SHALL be tied to 0, and entry SHALL wait indefinitely.

Verification
REQ-031 Debounce: raw_entry_sensor high for 3 cycles then low -> entry_sensor stays 0; held high -> entry_sensor=1 on the 4th edge with DEBOUNCE_CYCLES=4.
REQ-032 Normal entry: entry_sensor=1, key_strobe with key_code=1, then key_strobe with key_code=2 -> password_1=01, password_2=10, pwd_valid=1 on the next cycle; a third strobe leaves values unchanged.
REQ-033 Abort: after first digit 3, key_clear and key_strobe in the same cycle -> state DIGIT1, password_1=0, pwd_valid=0.
REQ-034 Car leaves: in VALID, raw_entry_sensor low for 4 cycles -> IDLE, passwords 00, pwd_valid=0.
REQ-035 Timeout (macro defined, TIMEOUT_CYCLES=64): one digit then 64 idle cycles -> timeout_pulse=1 for exactly one cycle, password_1=0; with the macro undefined -> no pulse and the digit is retained.
REQ-036 Reset mid-entry in DIGIT2 -> every output is 0 on the next cycle, and the state is IDLE even if raw_entry_sensor is still high.
